serial_adder: RTL and testbench

//  Bit-serial WIDTH-bit adder built around one instance of the team's 1-bit full-adder cell f_adder1.
//  - Accepts A, B and carry-in over a valid/ready handshake.
//  - Feeds the cell one bit pair per clock, LSB first, and keeps the carry in a register between bits.
//  - Returns the WIDTH-bit sum and the carry-out over a second valid/ready handshake.
//  - Sits directly upstream of the cell: it is the sequential stage that drives and consumes the cell.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_f_adder1.sv | 15 +
 rtl/serial_adder.sv | 97 +++++++++
 tb/tb_serial_adder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int ADDER_WIDTH_DEF = 8;

endpackage

// File: rtl/serial_adder_f_adder1.sv
// 1-bit full-adder cell; purely combinational.
module f_adder1 (
    input  logic ain,
    input  logic bin,
    input  logic cin,
    output logic sout,
    output logic cout
);

    always_comb begin
        sout = ain ^ bin ^ cin;
        cout = (ain & bin) | (cin & (ain ^ bin));
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one f_adder1 cell fed LSB first, carry held in a register,
// operands and result exchanged over valid/ready handshakes.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t            state;
    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic [WIDTH-1:0]  sum_sr;
    logic              carry_q;
    logic [CW-1:0]     cnt;
    logic              fa_s;
    logic              fa_c;
    logic [WIDTH-1:0]  sum_next;

    f_adder1 u_fa (
        .ain  (a_sr[0]),
        .bin  (b_sr[0]),
        .cin  (carry_q),
        .sout (fa_s),
        .cout (fa_c)
    );

    assign in_ready = (state == ST_IDLE);
    assign sum_next = {fa_s, sum_sr[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            sum_out   <= '0;
            c_out     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sr    <= a_in;
                        b_sr    <= b_in;
                        carry_q <= c_in;
                        cnt     <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    sum_sr  <= sum_next;
                    carry_q <= fa_c;
                    // cnt is cleared rather than incremented on the last bit so it never exceeds WIDTH-1
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        sum_out   <= sum_next;
                        c_out     <= fa_c;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): driver queues expected {c_out,sum_out}, monitor checks results.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic       c_in = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum_out;
    logic       c_out;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned acc_t   = 0;
    int unsigned n_push  = 0;
    int unsigned n_pop   = 0;
    logic [8:0]  exp_q[$];
    int unsigned pop_t[$];

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .c_out     (c_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a result transfers on the posedge following a negedge with out_valid && out_ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_pop++;
            pop_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_result", {c_out, sum_out}, 9'h1FF ^ {c_out, sum_out});
            end else begin
                chk("result", {c_out, sum_out}, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [8:0] exp, input bit push, input bit keep);
        bit ok = 1'b0;
        a_in = a; b_in = b; c_in = c; in_valid = 1'b1;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (in_ready && !rst) ok = 1'b1;
        end
        if (ok) begin
            acc_t = cyc;
            if (push) begin
                exp_q.push_back(exp);
                n_push++;
            end
        end else begin
            chk("send_timeout", 64'd0, 64'd1);
        end
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int unsigned acc[4];
        bit drv_done;

        // Reset state
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sum_out", sum_out, 0);
        chk("rst_c_out", c_out, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // 1: simple add and latency
        out_ready = 1'b0;
        send(8'h0F, 8'h01, 1'b0, 9'h010, 1, 0);
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (out_valid) lat = k;
        end
        chk("latency", lat, 8);
        out_ready = 1'b1;
        wait_drain();

        // 2: carry out and all-ones
        send(8'hFF, 8'h01, 1'b0, 9'h100, 1, 0);
        send(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1, 0);
        wait_drain();

        // 3: backpressure and ignored in_valid in DONE
        out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b0, 9'h046, 1, 0);
        for (int i = 0; i < 30 && !out_valid; i++) begin @(posedge clk); #1; end
        chk("bp_reach_done", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin in_valid = 1'b1; a_in = 8'hEE; b_in = 8'hEE; c_in = 1'b1; end
            if (k == 2) in_valid = 1'b0;
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_sum_stable", {c_out, sum_out}, 9'h046);
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_drain();
        send(8'h01, 8'h02, 1'b0, 9'h003, 1, 0);
        wait_drain();

        // 4: asynchronous reset mid-SHIFT discards the operation
        send(8'h33, 8'h44, 1'b0, 9'h077, 0, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_sum_out", sum_out, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        send(8'hA5, 8'h5A, 1'b0, 9'h0FF, 1, 0);
        wait_drain();

        // 5: back-to-back throughput with in_valid and out_ready held high
        pop_t.delete();
        send(8'h01, 8'h01, 1'b0, 9'h002, 1, 1); acc[0] = acc_t;
        send(8'h80, 8'h80, 1'b0, 9'h100, 1, 1); acc[1] = acc_t;
        send(8'h7F, 8'h00, 1'b1, 9'h080, 1, 1); acc[2] = acc_t;
        send(8'hC3, 8'h3C, 1'b1, 9'h100, 1, 0); acc[3] = acc_t;
        wait_drain();
        for (int i = 1; i < 4; i++) chk("b2b_accept_gap", acc[i] - acc[i-1], 10);
        chk("b2b_results", pop_t.size(), 4);
        if (pop_t.size() == 4)
            for (int i = 1; i < 4; i++) chk("b2b_result_gap", pop_t[i] - pop_t[i-1], 10);

        // 6: random operands with random stalls on both handshakes
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [7:0] ra, rb;
                    logic rc;
                    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc}, 1, 0);
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
        chk("push_pop_count", n_pop, n_push);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
